sd_serializer_var: RTL and testbench
====================================

# sd_serializer_var

Parametrised successor to the fixed-ratio serializer. Splits one wide `s_*` word into `N_PART = INPUT_WIDTH/OUTPUT_WIDTH` narrow `d_*` beats.

Additions over the fixed-ratio block:
- any integer ratio (not only powers of two)
- per-word part count (`s_len`)
- end-of-packet propagation
- selectable beat order
- zero-bubble back-to-back words

It sits between wide internal datapaths and narrow link/debug ports on valid/ready streams.

## Interface
Parameters:
- `INPUT_WIDTH`, 64, width of the input word; must be an integer multiple of `OUTPUT_WIDTH`.
- `OUTPUT_WIDTH`, 8, width of one output beat.
- `MSB_FIRST`, 0, beat order: 0 sends part 0 (bits `[OUTPUT_WIDTH-1:0]`) first; 1 sends the top part first.
- Derived: `N_PART = INPUT_WIDTH/OUTPUT_WIDTH`, must be ≥ 2 (sim-only assertion). `LEN_W = $clog2(N_PART+1)`.

Ports (one clock; reset is synchronous and active-low):
- `clk`, in, 1, clock; all state updates on posedge.
- `rstn`, in, 1, synchronous active-low reset.
- `s_valid`, in, 1, input word valid.
- `s_data`, in, `INPUT_WIDTH`, input word.
- `s_len`, in, `LEN_W`, number of parts to emit; 0 or > `N_PART` means `N_PART`.
- `s_last`, in, 1, word ends a packet.
- `s_ready`, out, 1, input accept.
- `d_valid`, out, 1, output beat valid.
- `d_data`, out, `OUTPUT_WIDTH`, output beat.
- `d_eow`, out, 1, current beat is the final beat of its word.
- `d_last`, out, 1, `d_eow & held s_last`.
- `d_ready`, in, 1, output accept.
- `busy`, out, 1, a word is held.

## Operation
- **Storage:** one holding register (data, effective length `len_q`, `last_q`) plus part counter `cnt` (`$clog2(N_PART)` bits). Two states:
  - ST_EMPTY: no word held.
  - ST_SER: word held, beats being emitted.
- **ST_EMPTY:**
  - `s_ready=1`, `d_valid=0`.
  - On `s_valid`: capture the word; `len_q = clamp(s_len)`; `cnt=0`; go to ST_SER.
- **ST_SER:**
  - `d_valid=1`.
  - Beat index `idx = MSB_FIRST ? (N_PART-1-cnt) : cnt`; `d_data = held[idx*OUTPUT_WIDTH +: OUTPUT_WIDTH]`.
  - `d_eow = (cnt == len_q-1)`.
  - On `d_ready & ~d_eow`: `cnt++`.
  - On `d_ready & d_eow`, when `s_valid`: capture the new word, `cnt=0`, stay in ST_SER.
  - On `d_ready & d_eow`, when `~s_valid`: go to ST_EMPTY.
- **`s_ready`:** equals `(state==ST_EMPTY) | (d_ready & d_eow)`. It is combinational from `d_ready`; there is no combinational path from `s_valid` to `s_ready`.
- **Flag visibility:** `s_last` is visible only on the final beat. Unused parts (index ≥ `len_q`) are never emitted.
- **Counter range:** `cnt` never exceeds `len_q-1`, so non-power-of-two `N_PART` cannot index outside `held`.
- **Stall behaviour:** `d_data`/`d_eow`/`d_last` stay stable while `d_valid & ~d_ready`. Held data changes only on capture.
- **Reset:** `rstn=0` at a posedge gives ST_EMPTY, `cnt=0`, `len_q=N_PART`, `last_q=0`; a held word is dropped.
  - Outputs after reset: `d_valid=0`, `d_eow=0`, `d_last=0`, `busy=0`, `s_ready=1`, `d_data=0`.
  - The holding register is cleared to 0.
- **`busy`:** equals `(state==ST_SER)`.

## Timing
- **Latency:** word accepted at edge T gives its first beat valid in cycle T+1 (registered). No combinational `s→d` path.
- **Throughput:** `len` beats per word with no idle cycle between words when `s_valid` is held. Sustained throughput is 1 beat/cycle under `d_ready=1`.
- **`len_q=1`:** every beat is `d_eow`. A word can be accepted every cycle, so the block acts as a 1-deep pipeline register.
- **Simultaneous events:** a final-beat handoff and a new accept happen in the same edge. The new word's beat 0 appears at the next cycle.
- **Reset mid-word:** no further beats of the dropped word appear. The first post-reset accept behaves as from ST_EMPTY.

## Test plan
- **Basic LSB-first:** `INPUT_WIDTH=32`, `OUTPUT_WIDTH=8`, `MSB_FIRST=0`, `s_data=0x44332211`, `s_len=0`, `s_last=1`, `d_ready=1`.
  - Beats `0x11,0x22,0x33,0x44` in cycles T+1..T+4.
  - `d_eow`/`d_last` high only on `0x44`.
  - `s_ready` high in cycle T+4.
- **MSB-first partial word:** same word, `MSB_FIRST=1`, `s_len=2`, `s_last=0`.
  - Beats `0x44,0x33` only.
  - `d_eow=1` and `d_last=0` on `0x33`.
- **Non-power-of-two ratio:** `INPUT_WIDTH=24`, `OUTPUT_WIDTH=8`, two words `0xCCBBAA` and `0x332211` back-to-back with `s_valid` held.
  - Six consecutive beats `AA,BB,CC,11,22,33` with no bubble.
  - Second accept occurs on the `CC` beat's edge.
- **Backpressure:** toggle `d_ready` 1,0,0,1,… during a 4-part word.
  - Each beat is held stable while stalled.
  - No beat lost or duplicated.
  - `s_ready=0` until the final beat's handshake.
- **Length clamp and `len=1` streaming:** `s_len=7` with `N_PART=4` emits 4 beats. `s_len=1` on 5 consecutive words emits one beat per word, 5 beats in 5 cycles, all with `d_eow=1`.
- **Reset mid-word:** assert `rstn=0` for 1 cycle after beat 1 of a 4-part word.
  - Next cycle: `d_valid=0`, `busy=0`, `s_ready=1`.
  - A new word then starts at its beat 0.

Source files
------------

// File: rtl/sd_serializer_var.sv
// sd_serializer_var: splits one wide input word into a per-word number of
// narrow output beats on valid/ready streams. Any integer ratio, selectable
// beat order, end-of-packet propagation and zero-bubble back-to-back words.
module sd_serializer_var #(
    parameter int INPUT_WIDTH  = 64,
    parameter int OUTPUT_WIDTH = 8,
    parameter int MSB_FIRST    = 0,
    localparam int N_PART      = INPUT_WIDTH / OUTPUT_WIDTH,
    localparam int LEN_W       = $clog2(N_PART + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_valid,
    input  logic [INPUT_WIDTH-1:0]  s_data,
    input  logic [LEN_W-1:0]        s_len,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    d_valid,
    output logic [OUTPUT_WIDTH-1:0] d_data,
    output logic                    d_eow,
    output logic                    d_last,
    input  logic                    d_ready,
    output logic                    busy
);

    localparam int CNT_W = (N_PART > 1) ? $clog2(N_PART) : 1;

    localparam logic [LEN_W-1:0] N_PART_L  = LEN_W'(N_PART);
    localparam logic [LEN_W:0]   N_PART_X  = (LEN_W + 1)'(N_PART);
    localparam logic [CNT_W-1:0] LAST_PART = CNT_W'(N_PART - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_SER   = 1'b1;

    logic [0:0]                          state_q;
    logic [N_PART-1:0][OUTPUT_WIDTH-1:0] held_q;
    logic [LEN_W-1:0]                    len_q;
    logic                                last_q;
    logic [CNT_W-1:0]                    cnt_q;

    logic                                in_ser;
    logic                                eow;
    logic                                accept;
    logic [LEN_W:0]                      len_ext;
    logic [LEN_W-1:0]                    len_clamped;
    logic [CNT_W-1:0]                    idx;

    // Beat selection, final-beat detection and the handshake decode; s_ready
    // depends on d_ready and held state only, never on s_valid
    always_comb begin
        in_ser      = (state_q == ST_SER);
        len_ext     = {1'b0, s_len};
        len_clamped = s_len;
        if (s_len == '0 || len_ext > N_PART_X) begin
            len_clamped = N_PART_L;
        end
        idx         = (MSB_FIRST != 0) ? (LAST_PART - cnt_q) : cnt_q;
        eow         = in_ser && (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));
        s_ready     = !in_ser || (d_ready && eow);
        accept      = s_valid && s_ready;
        d_valid     = in_ser;
        d_eow       = eow;
        d_last      = eow && last_q;
        busy        = in_ser;
        d_data      = in_ser ? held_q[idx] : '0;
    end

    // Holding register, part counter and the two-state control; a capture
    // on the final-beat handoff keeps the block in ST_SER with no bubble
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            held_q  <= '0;
            len_q   <= N_PART_L;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= ST_SER;
            held_q  <= s_data;
            len_q   <= len_clamped;
            last_q  <= s_last;
            cnt_q   <= '0;
        end else if (in_ser && d_ready) begin
            if (eow) begin
                state_q <= ST_EMPTY;
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-only sanity: the ratio must give at least two parts and the
    // counter must never point past the effective length of the held word
    always_ff @(posedge clk) begin
        assert (N_PART >= 2)
            else $error("sd_serializer_var: N_PART must be at least 2");
        if (rstn && in_ser) begin
            assert (LEN_W'(cnt_q) < len_q)
                else $error("sd_serializer_var: part counter beyond word length");
        end
    end
`endif

endmodule

// File: tb/tb_sd_serializer_var.sv
// tb_sd_serializer_var: drives three serializer instances (32/8 LSB-first,
// 32/8 MSB-first, 24/8 LSB-first) from one shared stimulus stream and checks
// every cycle against a beat-list reference model, plus table vectors and
// hand-written multi-cycle sequences.
module tb_sd_serializer_var;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic [31:0] s_data;
    logic [2:0]  s_len;
    logic        s_last;
    logic        d_ready;

    logic       a_s_ready, a_d_valid, a_d_eow, a_d_last, a_busy;
    logic [7:0] a_d_data;
    logic       b_s_ready, b_d_valid, b_d_eow, b_d_last, b_busy;
    logic [7:0] b_d_data;
    logic       c_s_ready, c_d_valid, c_d_eow, c_d_last, c_busy;
    logic [7:0] c_d_data;

    logic       o_sready [3];
    logic       o_valid  [3];
    logic       o_eow    [3];
    logic       o_last   [3];
    logic       o_busy   [3];
    logic [7:0] o_data   [3];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the remaining beats of the word each instance holds
    logic [7:0] m_data [3][4];
    logic       m_eow  [3][4];
    logic       m_last [3][4];
    int         m_rd   [3];
    int         m_n    [3];

    int         cap_n     [3];
    int         cap_eow   [3];
    logic [7:0] cap_first [3];
    logic [7:0] cap_final [3];
    logic       cap_lastf [3];

    typedef struct {
        logic [31:0] data;
        logic [2:0]  len;
        logic        last;
        int          na;
        logic [7:0]  a_first;
        logic [7:0]  a_final;
        logic [7:0]  b_first;
        logic [7:0]  b_final;
        int          nc;
        logic [7:0]  c_first;
        logic [7:0]  c_final;
    } vec_t;

    always #5 clk = ~clk;

    sd_serializer_var #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(8), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_len(s_len),
        .s_last(s_last), .s_ready(a_s_ready), .d_valid(a_d_valid), .d_data(a_d_data),
        .d_eow(a_d_eow), .d_last(a_d_last), .d_ready(d_ready), .busy(a_busy)
    );

    sd_serializer_var #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(8), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_len(s_len),
        .s_last(s_last), .s_ready(b_s_ready), .d_valid(b_d_valid), .d_data(b_d_data),
        .d_eow(b_d_eow), .d_last(b_d_last), .d_ready(d_ready), .busy(b_busy)
    );

    sd_serializer_var #(.INPUT_WIDTH(24), .OUTPUT_WIDTH(8), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data[23:0]), .s_len(s_len[1:0]),
        .s_last(s_last), .s_ready(c_s_ready), .d_valid(c_d_valid), .d_data(c_d_data),
        .d_eow(c_d_eow), .d_last(c_d_last), .d_ready(d_ready), .busy(c_busy)
    );

    // Gather the three instances' outputs into indexable arrays
    always_comb begin
        o_sready[0] = a_s_ready; o_valid[0] = a_d_valid; o_eow[0] = a_d_eow;
        o_last[0]   = a_d_last;  o_busy[0]  = a_busy;    o_data[0] = a_d_data;
        o_sready[1] = b_s_ready; o_valid[1] = b_d_valid; o_eow[1] = b_d_eow;
        o_last[1]   = b_d_last;  o_busy[1]  = b_busy;    o_data[1] = b_d_data;
        o_sready[2] = c_s_ready; o_valid[2] = c_d_valid; o_eow[2] = c_d_eow;
        o_last[2]   = c_d_last;  o_busy[2]  = c_busy;    o_data[2] = c_d_data;
    end

    function automatic void compare(string name, int k, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, k, act, exp);
        end
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] data, input logic [2:0] len,
                                 input logic last, input logic rdy);
        s_valid = v;
        s_data  = data;
        s_len   = len;
        s_last  = last;
        d_ready = rdy;
    endtask

    // Build the ordered beat list of a freshly accepted word from the rules:
    // clamp the length, pick part order, flag only the final beat
    task automatic loadWord(input int k);
        int          parts;
        int          lenv;
        int          n;
        logic [31:0] word;
        parts = (k == 2) ? 3 : 4;
        lenv  = (k == 2) ? int'(s_len[1:0]) : int'(s_len);
        word  = (k == 2) ? (s_data & 32'h00FF_FFFF) : s_data;
        n     = (lenv == 0 || lenv > parts) ? parts : lenv;
        for (int i = 0; i < n; i++) begin
            int p;
            p = (k == 1) ? (parts - 1 - i) : i;
            m_data[k][i] = 8'(word >> (8 * p));
            m_eow[k][i]  = (i == n - 1);
            m_last[k][i] = (i == n - 1) && s_last;
        end
        m_rd[k] = 0;
        m_n[k]  = n;
    endtask

    task automatic modelUpdate();
        for (int k = 0; k < 3; k++) begin
            logic rdy;
            if (!rstn) begin
                m_n[k]  = 0;
                m_rd[k] = 0;
            end else begin
                rdy = (m_n[k] == 0) || (d_ready && m_n[k] == 1);
                if (m_n[k] > 0 && d_ready) begin
                    m_rd[k]++;
                    m_n[k]--;
                end
                if (s_valid && rdy) loadWord(k);
            end
        end
    endtask

    task automatic checkOutput(input int k);
        logic exp_valid;
        logic exp_ready;
        exp_valid = (m_n[k] > 0);
        exp_ready = (m_n[k] == 0) || (d_ready && m_n[k] == 1);
        compare("d_valid", k, 32'(o_valid[k]), 32'(exp_valid));
        compare("busy",    k, 32'(o_busy[k]),  32'(exp_valid));
        compare("s_ready", k, 32'(o_sready[k]), 32'(exp_ready));
        if (exp_valid) begin
            compare("d_data", k, 32'(o_data[k]), 32'(m_data[k][m_rd[k]]));
            compare("d_eow",  k, 32'(o_eow[k]),  32'(m_eow[k][m_rd[k]]));
            compare("d_last", k, 32'(o_last[k]), 32'(m_last[k][m_rd[k]]));
        end
    endtask

    task automatic checkReset();
        for (int k = 0; k < 3; k++) begin
            compare("reset d_valid", k, 32'(o_valid[k]),  32'd0);
            compare("reset d_eow",   k, 32'(o_eow[k]),    32'd0);
            compare("reset d_last",  k, 32'(o_last[k]),   32'd0);
            compare("reset busy",    k, 32'(o_busy[k]),   32'd0);
            compare("reset s_ready", k, 32'(o_sready[k]), 32'd1);
            compare("reset d_data",  k, 32'(o_data[k]),   32'd0);
        end
    endtask

    task automatic clearCaps();
        for (int k = 0; k < 3; k++) begin
            cap_n[k]     = 0;
            cap_eow[k]   = 0;
            cap_first[k] = 8'h00;
            cap_final[k] = 8'h00;
            cap_lastf[k] = 1'b0;
        end
    endtask

    // One clock: check outputs mid-low-phase, log handshakes, advance model
    task automatic tick();
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput(k);
            if (o_valid[k] === 1'b1 && d_ready) begin
                cap_n[k]++;
                if (cap_n[k] == 1) cap_first[k] = o_data[k];
                if (o_eow[k] === 1'b1) begin
                    cap_final[k] = o_data[k];
                    cap_lastf[k] = o_last[k];
                    cap_eow[k]++;
                end
            end
        end
        modelUpdate();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        applyStimulus(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        while ((m_n[0] + m_n[1] + m_n[2]) > 0 && guard < 16) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        vec_t       vecs [5];
        logic [7:0] b2b_exp [6];

        rstn = 1'b0;
        applyStimulus(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            m_n[k]  = 0;
            m_rd[k] = 0;
        end
        clearCaps();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset();
        rstn = 1'b1;

        vecs[0] = '{32'h44332211, 3'd0, 1'b1, 4, 8'h11, 8'h44, 8'h44, 8'h11, 3, 8'h11, 8'h33};
        vecs[1] = '{32'h44332211, 3'd2, 1'b0, 2, 8'h11, 8'h22, 8'h44, 8'h33, 2, 8'h11, 8'h22};
        vecs[2] = '{32'hDEADBEEF, 3'd7, 1'b1, 4, 8'hEF, 8'hDE, 8'hDE, 8'hEF, 3, 8'hEF, 8'hAD};
        vecs[3] = '{32'h0A0B0C0D, 3'd1, 1'b1, 1, 8'h0D, 8'h0D, 8'h0A, 8'h0A, 1, 8'h0D, 8'h0D};
        vecs[4] = '{32'h12345678, 3'd3, 1'b0, 3, 8'h78, 8'h34, 8'h12, 8'h56, 3, 8'h78, 8'h34};
        b2b_exp = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};

        // Single words into an idle block: beat count, order and packet flag
        for (int v = 0; v < 5; v++) begin
            drain();
            clearCaps();
            applyStimulus(1'b1, vecs[v].data, vecs[v].len, vecs[v].last, 1'b1);
            tick();
            applyStimulus(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
            repeat (6) tick();
            compare($sformatf("vec%0d beats", v),   0, 32'(cap_n[0]),     32'(vecs[v].na));
            compare($sformatf("vec%0d first", v),   0, 32'(cap_first[0]), 32'(vecs[v].a_first));
            compare($sformatf("vec%0d final", v),   0, 32'(cap_final[0]), 32'(vecs[v].a_final));
            compare($sformatf("vec%0d d_last", v),  0, 32'(cap_lastf[0]), 32'(vecs[v].last));
            compare($sformatf("vec%0d beats", v),   1, 32'(cap_n[1]),     32'(vecs[v].na));
            compare($sformatf("vec%0d first", v),   1, 32'(cap_first[1]), 32'(vecs[v].b_first));
            compare($sformatf("vec%0d final", v),   1, 32'(cap_final[1]), 32'(vecs[v].b_final));
            compare($sformatf("vec%0d d_last", v),  1, 32'(cap_lastf[1]), 32'(vecs[v].last));
            compare($sformatf("vec%0d beats", v),   2, 32'(cap_n[2]),     32'(vecs[v].nc));
            compare($sformatf("vec%0d first", v),   2, 32'(cap_first[2]), 32'(vecs[v].c_first));
            compare($sformatf("vec%0d final", v),   2, 32'(cap_final[2]), 32'(vecs[v].c_final));
            compare($sformatf("vec%0d d_last", v),  2, 32'(cap_lastf[2]), 32'(vecs[v].last));
        end

        // Non-power-of-two ratio, back-to-back words with no bubble
        drain();
        applyStimulus(1'b1, 32'h00CCBBAA, 3'd0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 3, 32'h00332211, 3'd0, 1'b1, 1'b1);
            #1;
            compare($sformatf("b2b valid %0d", i),   2, 32'(o_valid[2]),  32'd1);
            compare($sformatf("b2b data %0d", i),    2, 32'(o_data[2]),   32'(b2b_exp[i]));
            compare($sformatf("b2b s_ready %0d", i), 2, 32'(o_sready[2]), 32'(i == 2 || i == 5));
            tick();
        end

        // Backpressure: d_ready 1,0,0,1,0,0,... over a 4-part word
        drain();
        clearCaps();
        applyStimulus(1'b1, 32'hA1B2C3D4, 3'd4, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 32'd0, 3'd0, 1'b0, (i % 3) == 0);
            tick();
        end
        compare("bp beats",  0, 32'(cap_n[0]),     32'd4);
        compare("bp first",  0, 32'(cap_first[0]), 32'hD4);
        compare("bp final",  0, 32'(cap_final[0]), 32'hA1);
        compare("bp d_last", 0, 32'(cap_lastf[0]), 32'd1);

        // len=1 streaming: one word per cycle acts as a pipeline register
        drain();
        clearCaps();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, $urandom, 3'd1, i == 4, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        tick();
        compare("len1 beats",     0, 32'(cap_n[0]),   32'd5);
        compare("len1 eow beats", 0, 32'(cap_eow[0]), 32'd5);
        compare("len1 beats",     2, 32'(cap_n[2]),   32'd5);

        // Reset after beat 1 of a 4-part word drops the word entirely
        drain();
        applyStimulus(1'b1, 32'h55667788, 3'd0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        tick();
        tick();
        rstn = 1'b0;
        tick();
        checkReset();
        rstn = 1'b1;
        applyStimulus(1'b1, 32'h99AABBCC, 3'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
        #1;
        compare("post-reset valid", 0, 32'(o_valid[0]), 32'd1);
        compare("post-reset beat0", 0, 32'(o_data[0]),  32'hCC);
        compare("post-reset beat0", 1, 32'(o_data[1]),  32'h99);
        tick();

        // Randomized traffic, stalls and occasional resets against the model
        for (int i = 0; i < 400; i++) begin
            rstn = ($urandom_range(0, 63) != 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            tick();
        end
        rstn = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
